clock_display_mux: RTL and testbench
====================================

// Module: clock_display_mux
// PURPOSE
//  Downstream stage of digital_clock: consumes binary sec/min/hour and drives a
//  6-digit multiplexed common-anode 7-segment display as HH MM SS.
//  Converts each field to two BCD digits, scans one digit per refresh tick,
//  and snapshots the time once per frame so a frame never mixes two times.
// PARAMETERS
//  SCAN_DIV  50_000  clk cycles per digit slot (1 kHz digit rate at 50 MHz); >=2
// PORTS
//  clk    in   1  system clock, 50 MHz, rising edge
//  reset  in   1  asynchronous, active-low reset (0 = in reset)
//  sec    in   6  seconds, binary, valid 0..59
//  min    in   6  minutes, binary, valid 0..59
//  hour   in   5  hours, binary, valid 0..23
//  an     out  6  digit enables, active-low; an[0]=sec ones .. an[5]=hour tens
//  seg    out  7  segments, active-low, seg[6:0]={g,f,e,d,c,b,a}
//  dp     out  1  decimal point / colon, active-low
// BEHAVIOUR
//  Reset (async, reset=0): div=0, idx=5, snapshot=0, blank=1;
//   an=6'b111111, seg=7'b1111111, dp=1 immediately, held until release.
//  Divider: div counts 0..SCAN_DIV-1 and wraps; tick=1 for the one cycle when
//   div==SCAN_DIV-1. First tick: SCAN_DIV cycles after reset release.
//  On tick edge: idx <= (idx==5)?0:idx+1; blank <= 0. When idx wraps 5->0 the
//   same edge captures {sec,min,hour} into the snapshot. Between wraps the
//   snapshot is frozen; input changes mid-frame do not affect the current frame.
//  Output latency: an/seg/dp registered; they reflect the idx/snapshot updated
//   by a tick on the clk edge following that tick (1 cycle). Held between ticks.
//  Exactly one an bit low at a time when blank=0: an = ~(6'b1 << idx).
//  Digit map: idx0 sec%10, idx1 sec/10, idx2 min%10, idx3 min/10,
//   idx4 hour%10, idx5 hour/10. Division by constant 10 is exact for 0..63.
//  Encoding (active-low): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001
//   5=0010010 6=0000010 7=1111000 8=0000000 9=0010000.
//  Out-of-range field (sec>59, min>59 or hour>23 in snapshot): both digits of
//   that field show dash seg=7'b0111111; other fields are unaffected.
//  Leading zeros are shown (hour 5 -> "05").
//  dp: 0 on idx2 and idx4 when snapshot sec is even, else 1; dp=1 on all
//   other digits and when blank=1.
//  Reset asserted mid-frame: outputs blank asynchronously; after release the scan
//   restarts at idx0 with a fresh snapshot at the first tick.
//  No combinational path from inputs to outputs.
// TESTING (bench uses SCAN_DIV=4)
//  1 reset=0 for 50 ns -> an=111111, seg=1111111, dp=1; release -> at the first
//    tick, then 1 cycle later, an=111110.
//  2 sec=37,min=5,hour=23 -> over idx0..5 seg=1111000,0110000,0010010,1000000,
//    0110000,0100100; an walks 111110..011111; wraps back to idx0.
//  3 sec=37; change sec to 42 while idx=3 -> idx4,5 unchanged; next frame idx0
//    shows 0100100 (2) and idx1 shows 0011001 (4).
//  4 min=60,hour=24,sec=9 -> idx2..5 seg=0111111; idx0=0010000, idx1=1000000.
//  5 sec=10 -> dp=0 only during idx2 and idx4; sec=11 -> dp=1 on every digit.
//  6 assert reset while idx=3 -> outputs blank the same cycle without waiting
//    for clk; after release the first lit digit is idx0 with the new snapshot.

Source files
------------

// File: rtl/clock_display_mux.sv
// clock_display_mux
//   Drives a 6-digit multiplexed common-anode 7-segment display as HH MM SS from
//   binary time fields. Each field becomes two BCD digits. One digit is scanned
//   per refresh tick. The time is snapshotted once per frame, so a frame never
//   mixes two different times.
//
// Parameters
//   SCAN_DIV  clk cycles per digit slot (>= 2)
//
// Ports
//   clk    in   1  system clock, rising edge
//   reset  in   1  asynchronous reset, active-low
//   sec    in   6  seconds, binary, valid 0..59
//   min    in   6  minutes, binary, valid 0..59
//   hour   in   5  hours, binary, valid 0..23
//   an     out  6  digit enables, active-low; an[0]=sec ones .. an[5]=hour tens
//   seg    out  7  segments, active-low, {g,f,e,d,c,b,a}
//   dp     out  1  decimal point / colon, active-low
module clock_display_mux #(
  parameter int unsigned SCAN_DIV = 50_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [4:0] hour,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned DivW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
  localparam logic [2:0] IdxLast = 3'd5;

  localparam logic [6:0] SegDash  = 7'b0111111;
  localparam logic [6:0] SegBlank = 7'b1111111;

  // Largest legal value of each field; anything above shows dashes.
  localparam logic [5:0] SecMax  = 6'd59;
  localparam logic [5:0] MinMax  = 6'd59;
  localparam logic [5:0] HourMax = 6'd23;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // Active-low 7-segment pattern for a BCD digit.
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SegDash;
    endcase
    return s;
  endfunction

  // Constant division by 10 is exact for the whole 6-bit range.
  function automatic logic [3:0] ones_of(input logic [5:0] v);
    return 4'(v % 6'd10);
  endfunction

  function automatic logic [3:0] tens_of(input logic [5:0] v);
    return 4'(v / 6'd10);
  endfunction

  // ---------------------------------------------------------------------------
  // Refresh divider
  // ---------------------------------------------------------------------------
  logic [DivW-1:0] div_q, div_d;
  logic            tick;

  assign tick = (div_q == DivLast);

  always_comb begin
    div_d = div_q + 1'b1;
    if (tick) begin
      div_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan index, blank flag and per-frame snapshot
  // ---------------------------------------------------------------------------
  logic [2:0] idx_q, idx_d;
  logic       blank_q, blank_d;
  logic [5:0] snap_sec_q, snap_sec_d;
  logic [5:0] snap_min_q, snap_min_d;
  logic [4:0] snap_hour_q, snap_hour_d;

  always_comb begin
    idx_d       = idx_q;
    blank_d     = blank_q;
    snap_sec_d  = snap_sec_q;
    snap_min_d  = snap_min_q;
    snap_hour_d = snap_hour_q;
    if (tick) begin
      blank_d = 1'b0;
      if (idx_q == IdxLast) begin
        // Frame boundary: start over at sec ones with a fresh copy of the time.
        idx_d       = 3'd0;
        snap_sec_d  = sec;
        snap_min_d  = min;
        snap_hour_d = hour;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Digit decode from the snapshot
  // ---------------------------------------------------------------------------
  logic [5:0] hour_ext;
  logic       sec_ok, min_ok, hour_ok;
  logic [6:0] sec_lo, sec_hi, min_lo, min_hi, hour_lo, hour_hi;

  assign hour_ext = {1'b0, snap_hour_q};
  assign sec_ok   = (snap_sec_q <= SecMax);
  assign min_ok   = (snap_min_q <= MinMax);
  assign hour_ok  = (hour_ext <= HourMax);

  always_comb begin
    sec_lo  = sec_ok  ? seg_of(ones_of(snap_sec_q)) : SegDash;
    sec_hi  = sec_ok  ? seg_of(tens_of(snap_sec_q)) : SegDash;
    min_lo  = min_ok  ? seg_of(ones_of(snap_min_q)) : SegDash;
    min_hi  = min_ok  ? seg_of(tens_of(snap_min_q)) : SegDash;
    hour_lo = hour_ok ? seg_of(ones_of(hour_ext))   : SegDash;
    hour_hi = hour_ok ? seg_of(tens_of(hour_ext))   : SegDash;
  end

  // ---------------------------------------------------------------------------
  // Output register next-state
  // ---------------------------------------------------------------------------
  logic [5:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;
  logic       colon_slot;

  // Colon blinks on the hour-ones and min-ones digits, lit on even seconds.
  assign colon_slot = (idx_q == 3'd2) || (idx_q == 3'd4);

  always_comb begin
    an_d  = '1;
    seg_d = SegBlank;
    dp_d  = 1'b1;
    if (!blank_q) begin
      an_d = ~(6'b000001 << idx_q);
      case (idx_q)
        3'd0:    seg_d = sec_lo;
        3'd1:    seg_d = sec_hi;
        3'd2:    seg_d = min_lo;
        3'd3:    seg_d = min_hi;
        3'd4:    seg_d = hour_lo;
        3'd5:    seg_d = hour_hi;
        default: seg_d = SegBlank;
      endcase
      dp_d = ~(colon_slot && !snap_sec_q[0]);
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q       <= '0;
      idx_q       <= IdxLast;
      blank_q     <= 1'b1;
      snap_sec_q  <= '0;
      snap_min_q  <= '0;
      snap_hour_q <= '0;
      an_q        <= '1;
      seg_q       <= SegBlank;
      dp_q        <= 1'b1;
    end else begin
      div_q       <= div_d;
      idx_q       <= idx_d;
      blank_q     <= blank_d;
      snap_sec_q  <= snap_sec_d;
      snap_min_q  <= snap_min_d;
      snap_hour_q <= snap_hour_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_clock_display_mux.sv
module tb_clock_display_mux;

  localparam int unsigned S = 4;
  localparam logic [6:0] DASH = 7'b0111111;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] sec, min;
  logic [4:0] hour;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks = 0;
  int errors = 0;

  clock_display_mux #(.SCAN_DIV(S)) dut (
    .clk   (clk),
    .reset (reset),
    .sec   (sec),
    .min   (min),
    .hour  (hour),
    .an    (an),
    .seg   (seg),
    .dp    (dp)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  // Segment table straight from the display encoding.
  logic [6:0] enc_tab [0:9];
  initial begin
    enc_tab[0] = 7'b1000000; enc_tab[1] = 7'b1111001; enc_tab[2] = 7'b0100100;
    enc_tab[3] = 7'b0110000; enc_tab[4] = 7'b0011001; enc_tab[5] = 7'b0010010;
    enc_tab[6] = 7'b0000010; enc_tab[7] = 7'b1111000; enc_tab[8] = 7'b0000000;
    enc_tab[9] = 7'b0010000;
  end

  function automatic logic [6:0] field_digit(input int v, input int maxv, input bit tens);
    if (v > maxv) return DASH;
    return tens ? enc_tab[v / 10] : enc_tab[v % 10];
  endfunction

  // Model: count clock edges since reset release and log the inputs seen at each edge.
  int n = 0;
  int log_sec [0:4095];
  int log_min [0:4095];
  int log_hour[0:4095];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      n = 0;
    end else begin
      n = n + 1;
      if (n < 4096) begin
        log_sec[n]  = int'(sec);
        log_min[n]  = int'(min);
        log_hour[n] = int'(hour);
      end
    end
  end

  // Tick k (k>=1) lands on edge k*S and is visible one edge later. Slot k-1 shows
  // digit (k-1)%6 of the frame whose snapshot was taken at its first tick edge.
  always @(negedge clk) begin
    logic [5:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    int t, slot, idx, e, vs, vm, vh;
    e_an  = '1;
    e_seg = 7'b1111111;
    e_dp  = 1'b1;
    if (reset && n > 0) begin
      t = (n - 1) / S;
      if (t > 0) begin
        slot = t - 1;
        idx  = slot % 6;
        e    = S * (1 + 6 * (slot / 6));
        vs   = log_sec[e];
        vm   = log_min[e];
        vh   = log_hour[e];
        e_an = ~(6'd1 << idx);
        case (idx)
          0: e_seg = field_digit(vs, 59, 1'b0);
          1: e_seg = field_digit(vs, 59, 1'b1);
          2: e_seg = field_digit(vm, 59, 1'b0);
          3: e_seg = field_digit(vm, 59, 1'b1);
          4: e_seg = field_digit(vh, 23, 1'b0);
          default: e_seg = field_digit(vh, 23, 1'b1);
        endcase
        e_dp = ((idx == 2 || idx == 4) && (vs % 2 == 0)) ? 1'b0 : 1'b1;
      end
    end
    cmp("model_an", {1'b0, an}, {1'b0, e_an});
    cmp("model_seg", seg, e_seg);
    cmp("model_dp", {6'd0, dp}, {6'd0, e_dp});
  end

  task automatic next_slot();
    repeat (S) @(negedge clk);
  endtask

  task automatic check_digit(input int k, input logic [6:0] s, input logic d);
    logic [5:0] a;
    a = ~(6'd1 << k);
    cmp($sformatf("dir_an_idx%0d", k), {1'b0, an}, {1'b0, a});
    cmp($sformatf("dir_seg_idx%0d", k), seg, s);
    cmp($sformatf("dir_dp_idx%0d", k), {6'd0, dp}, {6'd0, d});
  endtask

  task automatic check_blank(input string name);
    cmp({name, "_an"}, {1'b0, an}, 7'b0111111);
    cmp({name, "_seg"}, seg, 7'b1111111);
    cmp({name, "_dp"}, {6'd0, dp}, 7'd1);
  endtask

  initial begin
    // 1: reset, then first lit digit one cycle after the first tick
    reset = 1'b1;
    sec = 6'd37; min = 6'd5; hour = 5'd23;
    #1 reset = 1'b0;
    #2 check_blank("reset");
    #49 reset = 1'b1;
    repeat (S) @(negedge clk);
    check_blank("pre_tick");
    @(negedge clk);

    // 2: 23:05:37 across one frame, then wrap
    check_digit(0, 7'b1111000, 1'b1); next_slot();
    check_digit(1, 7'b0110000, 1'b1); next_slot();
    check_digit(2, 7'b0010010, 1'b1); next_slot();
    check_digit(3, 7'b1000000, 1'b1); next_slot();
    check_digit(4, 7'b0110000, 1'b1); next_slot();
    check_digit(5, 7'b0100100, 1'b1); next_slot();
    check_digit(0, 7'b1111000, 1'b1);

    // 3: change sec mid-frame; current frame keeps the old snapshot
    repeat (3) next_slot();
    sec = 6'd42;
    next_slot(); check_digit(4, 7'b0110000, 1'b1);
    next_slot(); check_digit(5, 7'b0100100, 1'b1);
    next_slot(); check_digit(0, 7'b0100100, 1'b0 ^ 1'b1);
    next_slot(); check_digit(1, 7'b0011001, 1'b1);

    // 4: out-of-range min and hour show dashes
    sec = 6'd9; min = 6'd60; hour = 5'd24;
    repeat (5) next_slot();
    check_digit(0, 7'b0010000, 1'b1); next_slot();
    check_digit(1, 7'b1000000, 1'b1); next_slot();
    check_digit(2, DASH, 1'b1); next_slot();
    check_digit(3, DASH, 1'b1); next_slot();
    check_digit(4, DASH, 1'b1); next_slot();
    check_digit(5, DASH, 1'b1);

    // 5: colon on even seconds only, 12:05:10 then 12:05:11
    sec = 6'd10; min = 6'd5; hour = 5'd12;
    next_slot(); check_digit(0, 7'b1000000, 1'b1);
    next_slot(); check_digit(1, 7'b1111001, 1'b1);
    next_slot(); check_digit(2, 7'b0010010, 1'b0);
    next_slot(); check_digit(3, 7'b1000000, 1'b1);
    next_slot(); check_digit(4, 7'b0100100, 1'b0);
    next_slot(); check_digit(5, 7'b1111001, 1'b1);
    sec = 6'd11;
    next_slot(); check_digit(0, 7'b1111001, 1'b1);
    next_slot(); check_digit(1, 7'b1111001, 1'b1);
    next_slot(); check_digit(2, 7'b0010010, 1'b1);
    next_slot(); check_digit(3, 7'b1000000, 1'b1);
    next_slot(); check_digit(4, 7'b0100100, 1'b1);
    next_slot(); check_digit(5, 7'b1111001, 1'b1);

    // 6: async reset at idx3, restart at idx0 with a fresh snapshot
    repeat (4) next_slot();
    #2;
    sec = 6'd1; min = 6'd2; hour = 5'd3;
    reset = 1'b0;
    #1 check_blank("async_reset");
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    repeat (S) @(negedge clk);
    check_blank("post_reset");
    @(negedge clk); check_digit(0, 7'b1111001, 1'b1);
    next_slot(); check_digit(1, 7'b1000000, 1'b1);
    next_slot(); check_digit(2, 7'b0100100, 1'b1);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
